sdio_dat_tx_feeder: RTL and testbench

- Byte source for the SDIO DAT-line transmitter; sits directly upstream of sd_response_stream_dat inside sdio_slave.
- Buffers bytes produced by FPGA-side logic in an internal FIFO.
- On a read-data request from sdio_commands_processor (write_data4_strobe + data4_count), it starts the DAT transmitter and answers each data_req with one byte.
- Signals data_empty after exactly the requested byte count.

---
 rtl/sdio_pkg.sv | 16 +
 rtl/sdio_byte_fifo.sv | 55 +++++
 rtl/sdio_dat_tx_feeder.sv | 118 +++++++++++
 tb/tb_sdio_dat_tx_feeder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdio_pkg.sv
// Shared types and constants for the SDIO DAT transmit byte feeder.
package sdio_pkg;

  localparam int unsigned SDIO_BLOCK_MAX = 512;

  typedef logic [8:0] data4_count_t;
  typedef logic [9:0] remaining_t;

  typedef enum logic {IDLE, ACTIVE} feeder_state_t;

  // A data4 count of zero encodes a full 512-byte block.
  function automatic remaining_t block_len(input data4_count_t count);
    return (count == '0) ? remaining_t'(SDIO_BLOCK_MAX) : remaining_t'(count);
  endfunction

endpackage

// File: rtl/sdio_byte_fifo.sv
// Single-clock byte FIFO: inferred RAM, registered read, occupancy level output.
module sdio_byte_fifo #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // DEPTH is a power of two, so the level MSB alone marks full.
  assign full    = level[AW];
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sdio_dat_tx_feeder.sv
// Byte source for the SDIO DAT transmitter: buffers producer bytes and serves
// exactly the requested count of bytes per read-data request.
module sdio_dat_tx_feeder
  import sdio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter logic [7:0]  PAD_BYTE   = 8'hFF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          write_data4_strobe,
  input  logic [8:0]                    data4_count,
  output logic                          start_write,
  input  logic                          data_req,
  output logic [7:0]                    data,
  output logic                          data_strobe,
  output logic                          data_empty,
  output logic                          busy,
  output logic                          underrun
);

  feeder_state_t state, state_n;
  remaining_t    remaining, remaining_n;
  logic          start_n, strobe_n, empty_n, busy_n, underrun_n;
  logic          pad_sel, pad_sel_n;
  logic          pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_q;

  sdio_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (in_valid),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (fifo_q),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign in_ready = !fifo_full;

  // The FIFO read register already supplies the one-cycle latency, so the
  // output byte is a mux of that register and the pad byte; both hold between strobes.
  assign data = pad_sel ? PAD_BYTE : fifo_q;

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    start_n     = 1'b0;
    strobe_n    = 1'b0;
    empty_n     = data_empty;
    busy_n      = busy;
    underrun_n  = underrun;
    pad_sel_n   = pad_sel;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (write_data4_strobe) begin
          remaining_n = block_len(data4_count);
          start_n     = 1'b1;
          empty_n     = 1'b0;
          busy_n      = 1'b1;
          underrun_n  = 1'b0;
          state_n     = ACTIVE;
        end
      end
      ACTIVE: begin
        if (data_req) begin
          if (remaining != '0) begin
            strobe_n    = 1'b1;
            remaining_n = remaining - 10'd1;
            if (fifo_empty) begin
              pad_sel_n  = 1'b1;
              underrun_n = 1'b1;
            end else begin
              pop       = 1'b1;
              pad_sel_n = 1'b0;
            end
          end else begin
            empty_n = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      remaining   <= '0;
      start_write <= 1'b0;
      data_strobe <= 1'b0;
      data_empty  <= 1'b1;
      busy        <= 1'b0;
      underrun    <= 1'b0;
      pad_sel     <= 1'b0;
    end else begin
      state       <= state_n;
      remaining   <= remaining_n;
      start_write <= start_n;
      data_strobe <= strobe_n;
      data_empty  <= empty_n;
      busy        <= busy_n;
      underrun    <= underrun_n;
      pad_sel     <= pad_sel_n;
    end
  end

endmodule

// File: tb/tb_sdio_dat_tx_feeder.sv
// Self-checking bench for sdio_dat_tx_feeder: vector table, directed sequences
// and randomized traffic against a queue-based transaction model.
module tb_sdio_dat_tx_feeder;

  localparam int         DEPTH = 1024;
  localparam int         LW    = $clog2(DEPTH) + 1;
  localparam logic [7:0] PAD   = 8'hFF;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] fifo_level;
  logic          write_data4_strobe = 1'b0;
  logic [8:0]    data4_count = '0;
  logic          start_write;
  logic          data_req = 1'b0;
  logic [7:0]    data;
  logic          data_strobe;
  logic          data_empty;
  logic          busy;
  logic          underrun;

  always #5 clock = ~clock;

  sdio_dat_tx_feeder #(.FIFO_DEPTH(DEPTH), .PAD_BYTE(PAD)) dut (
    .clock              (clock),
    .reset              (reset),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .fifo_level         (fifo_level),
    .write_data4_strobe (write_data4_strobe),
    .data4_count        (data4_count),
    .start_write        (start_write),
    .data_req           (data_req),
    .data               (data),
    .data_strobe        (data_strobe),
    .data_empty         (data_empty),
    .busy               (busy),
    .underrun           (underrun)
  );

  int errors = 0;
  int checks = 0;
  int strobes_seen = 0;

  // Transaction-level model: byte queue, bytes left in the transfer, flags.
  logic [7:0] mq[$];
  int         m_rem = 0;
  bit         m_active = 0, m_under = 0, m_empty = 1, m_start = 0, m_strobe = 0;
  logic [7:0] m_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit v, input logic [7:0] d, input bit ws,
                      input logic [8:0] cnt, input bit req);
    bit pushed;
    reset = rst; in_valid = v; in_data = d;
    write_data4_strobe = ws; data4_count = cnt; data_req = req;
    @(posedge clock); #1;
    m_start = 0; m_strobe = 0;
    if (rst) begin
      mq.delete(); m_rem = 0; m_active = 0; m_under = 0; m_empty = 1; m_data = '0;
    end else begin
      pushed = v && (mq.size() < DEPTH);
      if (!m_active) begin
        if (ws) begin
          m_rem = (cnt == 0) ? 512 : int'(cnt);
          m_active = 1; m_under = 0; m_empty = 0; m_start = 1;
        end
      end else if (req) begin
        if (m_rem > 0) begin
          m_strobe = 1; m_rem--;
          if (mq.size() > 0) m_data = mq.pop_front();
          else begin m_data = PAD; m_under = 1; end
        end else begin
          m_active = 0; m_empty = 1;
        end
      end
      if (pushed) mq.push_back(d);
    end
    chk("in_ready", in_ready, mq.size() < DEPTH);
    chk("fifo_level", fifo_level, mq.size());
    chk("start_write", start_write, m_start);
    chk("data_strobe", data_strobe, m_strobe);
    chk("data", data, m_data);
    chk("data_empty", data_empty, m_empty);
    chk("busy", busy, m_active);
    chk("underrun", underrun, m_under);
    if (data_strobe) strobes_seen++;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 9'd0, 0);
  endtask
  task automatic push(input logic [7:0] b); step(0, 1, b, 0, 9'd0, 0); endtask
  task automatic go(input logic [8:0] c);   step(0, 0, 8'h00, 1, c, 0); endtask
  task automatic rq();                      step(0, 0, 8'h00, 0, 9'd0, 1); endtask
  task automatic rst_step();                step(1, 0, 8'h00, 0, 9'd0, 0); endtask

  typedef struct {
    bit v; logic [7:0] d; bit ws; logic [8:0] cnt; bit req;
    bit e_start; bit e_strobe; logic [7:0] e_data; bit e_empty; bit e_busy; bit e_under; int e_level;
  } vec_t;
  vec_t tbl[15];

  initial begin
    //           v  d      ws cnt req  start strobe data   empty busy under level
    tbl[0]  = '{1, 8'hAA, 0, 0, 0,    0, 0, 8'h00, 1, 0, 0, 1};
    tbl[1]  = '{1, 8'hBB, 0, 0, 0,    0, 0, 8'h00, 1, 0, 0, 2};
    tbl[2]  = '{1, 8'hCC, 0, 0, 0,    0, 0, 8'h00, 1, 0, 0, 3};
    tbl[3]  = '{0, 8'h00, 1, 5, 0,    1, 0, 8'h00, 0, 1, 0, 3};
    tbl[4]  = '{0, 8'h00, 0, 0, 0,    0, 0, 8'h00, 0, 1, 0, 3};
    tbl[5]  = '{0, 8'h00, 0, 0, 1,    0, 1, 8'hAA, 0, 1, 0, 2};
    tbl[6]  = '{0, 8'h00, 0, 0, 0,    0, 0, 8'hAA, 0, 1, 0, 2};
    tbl[7]  = '{0, 8'h00, 0, 0, 1,    0, 1, 8'hBB, 0, 1, 0, 1};
    tbl[8]  = '{0, 8'h00, 0, 0, 1,    0, 1, 8'hCC, 0, 1, 0, 0};
    tbl[9]  = '{0, 8'h00, 0, 0, 1,    0, 1, 8'hFF, 0, 1, 1, 0};
    tbl[10] = '{0, 8'h00, 0, 0, 1,    0, 1, 8'hFF, 0, 1, 1, 0};
    tbl[11] = '{0, 8'h00, 0, 0, 1,    0, 0, 8'hFF, 1, 0, 1, 0};
    tbl[12] = '{0, 8'h00, 1, 1, 0,    1, 0, 8'hFF, 0, 1, 0, 0};
    tbl[13] = '{0, 8'h00, 0, 0, 1,    0, 1, 8'hFF, 0, 1, 1, 0};
    tbl[14] = '{0, 8'h00, 0, 0, 1,    0, 0, 8'hFF, 1, 0, 1, 0};

    // Reset values
    rst_step();
    rst_step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_data", data, 8'h00);
    chk("rst_data_empty", data_empty, 1);
    chk("rst_busy", busy, 0);

    // Vector table: short buffer, underrun padding, underrun cleared by next request
    for (int i = 0; i < 15; i++) begin
      step(0, tbl[i].v, tbl[i].d, tbl[i].ws, tbl[i].cnt, tbl[i].req);
      chk($sformatf("tbl%0d_start", i),  start_write, tbl[i].e_start);
      chk($sformatf("tbl%0d_strobe", i), data_strobe, tbl[i].e_strobe);
      chk($sformatf("tbl%0d_data", i),   data,        tbl[i].e_data);
      chk($sformatf("tbl%0d_empty", i),  data_empty,  tbl[i].e_empty);
      chk($sformatf("tbl%0d_busy", i),   busy,        tbl[i].e_busy);
      chk($sformatf("tbl%0d_under", i),  underrun,    tbl[i].e_under);
      chk($sformatf("tbl%0d_level", i),  fifo_level,  tbl[i].e_level);
    end

    // 8-byte transfer, requests 4 cycles apart
    rst_step();
    for (int i = 0; i < 8; i++) push(8'(i));
    go(9'd8);
    strobes_seen = 0;
    for (int i = 0; i < 9; i++) begin rq(); idle(3); end
    chk("t8_strobes", strobes_seen, 8);
    chk("t8_level", fifo_level, 0);
    chk("t8_underrun", underrun, 0);
    chk("t8_empty", data_empty, 1);

    // Count 0 means a 512-byte block; leftover bytes stay buffered
    for (int i = 0; i < 600; i++) push(8'(i & 8'hFF));
    go(9'd0);
    strobes_seen = 0;
    for (int i = 0; i < 513; i++) rq();
    chk("t512_strobes", strobes_seen, 512);
    chk("t512_empty", data_empty, 1);
    chk("t512_level", fifo_level, 88);

    // Fill to full, ignored push, pop with simultaneous push
    for (int i = 0; i < DEPTH - 88; i++) push(8'($urandom));
    push(8'h5A);
    chk("full_level", fifo_level, DEPTH);
    chk("full_in_ready", in_ready, 0);
    go(9'd3);
    step(0, 1, 8'h11, 0, 9'd0, 1);
    chk("full_pop_level", fifo_level, DEPTH - 1);
    step(0, 1, 8'h22, 0, 9'd0, 1);
    chk("pushpop_level", fifo_level, DEPTH - 1);
    rq(); rq();
    chk("full_done_empty", data_empty, 1);

    // Reset in the middle of a transfer, then a fresh transfer
    rst_step();
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    go(9'd8);
    rq(); rq();
    rst_step();
    chk("midrst_busy", busy, 0);
    chk("midrst_empty", data_empty, 1);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_strobe", data_strobe, 0);
    for (int i = 0; i < 4; i++) push(8'h90 + 8'(i));
    go(9'd4);
    strobes_seen = 0;
    for (int i = 0; i < 5; i++) rq();
    chk("after_rst_strobes", strobes_seen, 4);
    chk("after_rst_empty", data_empty, 1);

    // Request in IDLE, request coinciding with strobe, strobe during ACTIVE
    rq(); rq();
    chk("idle_req_strobe", data_strobe, 0);
    push(8'h31); push(8'h32);
    step(0, 0, 8'h00, 1, 9'd2, 1);
    chk("ws_req_strobe", data_strobe, 0);
    step(0, 0, 8'h00, 1, 9'd7, 0);
    chk("ws_active_start", start_write, 0);
    rq(); rq();
    chk("ws_active_data", data, 8'h32);
    rq();
    chk("ws_active_end", data_empty, 1);

    // Randomized traffic until at least 3*DEPTH bytes have passed (pointer wrap)
    strobes_seen = 0;
    for (int i = 0; i < 20000 && strobes_seen < 3 * DEPTH; i++) begin
      step(0, $urandom_range(0, 99) < 70, 8'($urandom),
           m_active ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 5) == 0),
           9'($urandom), $urandom_range(0, 99) < 80);
    end
    chk("wrap_bytes_reached", strobes_seen >= 3 * DEPTH, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
